// File: rtl/contador_pkg.sv
// contador_pkg: shared sequence table, sizes, state enumeration and value type.
package contador_pkg;
    localparam int SEQ_LEN = 8;
    typedef logic [3:0] val_t;
    typedef logic [2:0] idx_t;
    typedef enum logic [1:0] {HUNT, CONFIRM, LOCKED} state_t;
    localparam val_t SEQ [SEQ_LEN] = '{4'd0, 4'd4, 4'd14, 4'd6, 4'd3, 4'd12, 4'd11, 4'd13};
    // A 3-bit index wraps on its own, so index 7 rolls to index 0.
    function automatic idx_t succ(idx_t i);
        return i + idx_t'(1);
    endfunction
endpackage

// File: rtl/contador_decode.sv
// contador_decode: maps an observed value to its legal flag and sequence index.
//   i_val   : observed 4-bit counter value
//   o_legal : value belongs to the sequence
//   o_idx   : position of the value in the sequence (0 when illegal)
module contador_decode
    import contador_pkg::*;
(
    input  val_t i_val,
    output logic o_legal,
    output idx_t o_idx
);
    always_comb begin
        o_legal = 1'b0;
        o_idx   = '0;
        for (int k = 0; k < SEQ_LEN; k++) begin
            if (i_val == SEQ[k]) begin
                o_legal = 1'b1;
                o_idx   = idx_t'(k);
            end
        end
    end
endmodule

// File: rtl/contador_monitor.sv
// contador_monitor: tracks a fixed 8-value counter sequence and reports lock and errors.
//   C      : clock, rising edge
//   RN     : asynchronous active-low reset
//   D, V   : observed value and its valid strobe
//   IDX    : index of the last accepted value
//   LOCK   : tracking the sequence
//   ERR    : one-cycle pulse on a mismatch while locked
//   WRAP   : one-cycle pulse when value 0 is accepted while locked
//   ERRCNT : saturating mismatch count
module contador_monitor
    import contador_pkg::*;
#(
    parameter int ERRW     = 8,
    parameter int MISS_MAX = 2
) (
    input  logic            C,
    input  logic            RN,
    input  logic [3:0]      D,
    input  logic            V,
    output logic [2:0]      IDX,
    output logic            LOCK,
    output logic            ERR,
    output logic            WRAP,
    output logic [ERRW-1:0] ERRCNT
);
    localparam int MW = $clog2(MISS_MAX + 1);
    state_t          r_state;
    idx_t            r_idx;
    idx_t            r_exp;
    logic [MW-1:0]   r_miss;
    logic            r_lock;
    logic            r_err;
    logic            r_wrap;
    logic [ERRW-1:0] r_cnt;
    logic            w_legal;
    idx_t            w_idx;
    logic            w_match;
    logic            w_drop;
    contador_decode u_decode (
        .i_val  (D),
        .o_legal(w_legal),
        .o_idx  (w_idx)
    );
    assign w_match = D == SEQ[r_exp];
    // The current miss is the one that reaches the limit.
    assign w_drop  = r_miss == MW'(MISS_MAX - 1);
    always_ff @(posedge C or negedge RN) begin
        if (!RN) begin
            r_state <= HUNT;
            r_idx   <= '0;
            r_exp   <= '0;
            r_miss  <= '0;
            r_lock  <= 1'b0;
            r_err   <= 1'b0;
            r_wrap  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_err  <= 1'b0;
            r_wrap <= 1'b0;
            if (V) begin
                case (r_state)
                    HUNT: begin
                        if (w_legal) begin
                            r_idx   <= w_idx;
                            r_exp   <= succ(w_idx);
                            r_state <= CONFIRM;
                        end
                    end
                    CONFIRM: begin
                        if (!w_legal) begin
                            r_state <= HUNT;
                        end else begin
                            r_idx <= w_idx;
                            r_exp <= succ(w_idx);
                            if (w_match) begin
                                r_state <= LOCKED;
                                r_lock  <= 1'b1;
                            end
                        end
                    end
                    LOCKED: begin
                        // Expected value advances even on a miss so one bad sample is tolerated.
                        r_exp <= succ(r_exp);
                        if (w_match) begin
                            r_idx  <= w_idx;
                            r_miss <= '0;
                            r_wrap <= w_idx == '0;
                        end else begin
                            r_err <= 1'b1;
                            r_cnt <= &r_cnt ? r_cnt : r_cnt + ERRW'(1);
                            if (w_drop) begin
                                r_state <= HUNT;
                                r_lock  <= 1'b0;
                                r_miss  <= '0;
                            end else begin
                                r_miss <= r_miss + MW'(1);
                            end
                        end
                    end
                    default: r_state <= HUNT;
                endcase
            end
        end
    end
    assign IDX    = r_idx;
    assign LOCK   = r_lock;
    assign ERR    = r_err;
    assign WRAP   = r_wrap;
    assign ERRCNT = r_cnt;
endmodule

// File: tb/tb_contador_monitor.sv
// tb_contador_monitor: randomized and directed checks of contador_monitor against a behavioural model.
module tb_contador_monitor;
    logic       C = 1'b0;
    logic       RN = 1'b0;
    logic       V = 1'b0;
    logic [3:0] D = 4'd0;
    logic [2:0] idx8, idx2;
    logic       lock8, lock2, err8, err2, wrap8, wrap2;
    logic [7:0] cnt8;
    logic [1:0] cnt2;
    int n_chk = 0;
    int n_fail = 0;
    contador_monitor #(.ERRW(8), .MISS_MAX(2)) u8 (
        .C(C), .RN(RN), .D(D), .V(V),
        .IDX(idx8), .LOCK(lock8), .ERR(err8), .WRAP(wrap8), .ERRCNT(cnt8)
    );
    contador_monitor #(.ERRW(2), .MISS_MAX(2)) u2 (
        .C(C), .RN(RN), .D(D), .V(V),
        .IDX(idx2), .LOCK(lock2), .ERR(err2), .WRAP(wrap2), .ERRCNT(cnt2)
    );
    always #5 C = ~C;
    int seq [8] = '{0, 4, 14, 6, 3, 12, 11, 13};
    localparam int S_HUNT = 0, S_CONF = 1, S_LOCK = 2;
    int m_state = S_HUNT, m_idx = 0, m_exp = 0, m_miss = 0, m_cnt = 0, m_err = 0, m_wrap = 0;
    function automatic int pos_of(int v);
        for (int i = 0; i < 8; i++) if (seq[i] == v) return i;
        return -1;
    endfunction
    function automatic int sat(int c, int m);
        return c > m ? m : c;
    endfunction
    function automatic void chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endfunction
    // Reference behaviour: sequence positions and counts as plain integers.
    always @(posedge C or negedge RN) begin
        if (!RN) begin
            m_state = S_HUNT; m_idx = 0; m_exp = 0; m_miss = 0; m_cnt = 0; m_err = 0; m_wrap = 0;
        end else begin
            int p;
            p = pos_of(int'(D));
            m_err = 0;
            m_wrap = 0;
            if (V) begin
                if (m_state == S_HUNT) begin
                    if (p >= 0) begin m_idx = p; m_exp = (p + 1) % 8; m_state = S_CONF; end
                end else if (m_state == S_CONF) begin
                    if (p < 0) m_state = S_HUNT;
                    else begin
                        if (p == m_exp) m_state = S_LOCK;
                        m_idx = p;
                        m_exp = (p + 1) % 8;
                    end
                end else begin
                    if (p == m_exp) begin
                        m_idx = p; m_miss = 0; m_wrap = (p == 0) ? 1 : 0;
                    end else begin
                        m_err = 1; m_cnt++; m_miss++;
                        if (m_miss >= 2) begin m_state = S_HUNT; m_miss = 0; end
                    end
                    m_exp = (m_exp + 1) % 8;
                end
            end
        end
    end
    always @(negedge C) begin
        chk("idx8", int'(idx8), m_idx);
        chk("lock8", int'(lock8), m_state == S_LOCK ? 1 : 0);
        chk("err8", int'(err8), m_err);
        chk("wrap8", int'(wrap8), m_wrap);
        chk("cnt8", int'(cnt8), sat(m_cnt, 255));
        chk("idx2", int'(idx2), m_idx);
        chk("lock2", int'(lock2), m_state == S_LOCK ? 1 : 0);
        chk("err2", int'(err2), m_err);
        chk("wrap2", int'(wrap2), m_wrap);
        chk("cnt2", int'(cnt2), sat(m_cnt, 3));
    end
    task automatic step(input int d, input bit v);
        @(negedge C);
        #1;
        D = 4'(d);
        V = v;
        @(posedge C);
        #1;
    endtask
    initial begin
        int miss_list [9] = '{1, 0, 1, 14, 1, 3, 1, 11, 1};
        repeat (2) @(negedge C);
        #1;
        chk("rst_idx", int'(idx8), 0);
        chk("rst_lock", int'(lock8), 0);
        chk("rst_err", int'(err8), 0);
        chk("rst_wrap", int'(wrap8), 0);
        chk("rst_cnt", int'(cnt8), 0);
        RN = 1'b1;
        step(0, 1);
        chk("seq0_lock", int'(lock8), 0);
        chk("seq0_idx", int'(idx8), 0);
        step(4, 1);
        chk("seq4_lock", int'(lock8), 1);
        chk("seq4_idx", int'(idx8), 1);
        for (int i = 2; i < 8; i++) begin
            step(seq[i], 1);
            chk("seq_idx", int'(idx8), i);
            chk("seq_wrap", int'(wrap8), 0);
        end
        step(0, 1);
        chk("wrap_idx", int'(idx8), 0);
        chk("wrap_pulse", int'(wrap8), 1);
        step(0, 0);
        chk("wrap_gone", int'(wrap8), 0);
        chk("hold_lock", int'(lock8), 1);
        step(4, 1);
        step(14, 1);
        chk("at2_idx", int'(idx8), 2);
        step(9, 1);
        chk("one_err", int'(err8), 1);
        chk("one_cnt", int'(cnt8), 1);
        chk("one_lock", int'(lock8), 1);
        chk("one_idx", int'(idx8), 2);
        step(3, 1);
        chk("recov_err", int'(err8), 0);
        chk("recov_idx", int'(idx8), 4);
        chk("recov_lock", int'(lock8), 1);
        step(7, 1);
        chk("two_err1", int'(err8), 1);
        chk("two_cnt1", int'(cnt8), 2);
        chk("two_lock1", int'(lock8), 1);
        step(7, 1);
        chk("two_err2", int'(err8), 1);
        chk("two_cnt2", int'(cnt8), 3);
        chk("two_lock2", int'(lock8), 0);
        step(7, 0);
        chk("hunt_err", int'(err8), 0);
        step(5, 1);
        step(8, 1);
        chk("hunt_lock", int'(lock8), 0);
        step(12, 1);
        chk("conf_lock", int'(lock8), 0);
        chk("conf_idx", int'(idx8), 5);
        step(11, 1);
        chk("relock", int'(lock8), 1);
        chk("relock_idx", int'(idx8), 6);
        foreach (miss_list[i]) step(miss_list[i], 1);
        chk("sat_lock", int'(lock8), 1);
        chk("sat_cnt8", int'(cnt8), 8);
        chk("sat_cnt2", int'(cnt2), 3);
        step(0, 0);
        #2 RN = 1'b0;
        #1;
        chk("arst_lock", int'(lock8), 0);
        chk("arst_cnt8", int'(cnt8), 0);
        chk("arst_cnt2", int'(cnt2), 0);
        #1 RN = 1'b1;
        step(0, 1);
        chk("rl_lock0", int'(lock8), 0);
        chk("rl_idx0", int'(idx8), 0);
        step(4, 1);
        chk("rl_lock1", int'(lock8), 1);
        chk("rl_idx1", int'(idx8), 1);
        for (int n = 0; n < 800; n++) begin
            @(negedge C);
            #1;
            V = $urandom_range(0, 3) != 0;
            D = $urandom_range(0, 1) != 0 ? 4'(seq[m_exp]) : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 149) == 0) begin
                #1 RN = 1'b0;
                #1 RN = 1'b1;
            end
        end
        @(negedge C);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
